alu_operand_sequencer: RTL and testbench

//  Upstream stage of the 6-bit AorB ALU.

---
 rtl/alu_operand_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Upstream stage of the 6-bit AorB ALU. Operand A, operand B and the function code are
//   captured one after another from a shared switch bus, one load event per field. When all
//   three are held, the stage presents them to the ALU with a valid/ready handshake. Every
//   output is driven straight from a register.
//
// Optional feature: define ALU_SEQ_LOAD_EDGE_EN to treat load as a level input. Only its
//   rising edge counts as a capture. Without the macro, every high cycle of load is a capture.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   sw         in   [WIDTH-1:0] data switches, sampled on a load event
//   load       in   capture strobe (pulse, or level when ALU_SEQ_LOAD_EDGE_EN is defined)
//   clear      in   synchronous abort; zeroes the operands and returns to S_A
//   op_ready   in   downstream accepts the operation
//   a_out      out  [WIDTH-1:0] operand A
//   b_out      out  [WIDTH-1:0] operand B
//   fxn_out    out  [FXN_W-1:0] function code
//   op_valid   out  operation complete and offered
//   state_out  out  [1:0] 0=S_A 1=S_B 2=S_F 3=S_ISSUE
//   op_count   out  [CNT_W-1:0] accepted operations, wraps silently
module alu_operand_sequencer #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned FXN_W = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw,
   input  logic             load,
   input  logic             clear,
   input  logic             op_ready,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [FXN_W-1:0] fxn_out,
   output logic             op_valid,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] op_count
);

   // S_ISSUE is fixed at 2'b11 because state_out drives the LEDs.
   localparam logic [1:0] S_A     = 2'b00;
   localparam logic [1:0] S_B     = 2'b01;
   localparam logic [1:0] S_F     = 2'b10;
   localparam logic [1:0] S_ISSUE = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [FXN_W-1:0] fxn_q, fxn_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ld;

`ifdef ALU_SEQ_LOAD_EDGE_EN
   // A held button advances exactly one field: only the rising edge of load counts.
   logic load_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_q <= 1'b0;
      end else begin
         load_q <= load;
      end
   end

   assign ld = load & ~load_q;
`else
   assign ld = load;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      fxn_d   = fxn_q;
      valid_d = valid_q;
      count_d = count_q;
      if (clear) begin
         // Abort has priority over ld and the handshake; op_count is preserved.
         state_d = S_A;
         a_d     = '0;
         b_d     = '0;
         fxn_d   = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_A: begin
               if (ld) begin
                  a_d     = sw;
                  state_d = S_B;
               end
            end
            S_B: begin
               if (ld) begin
                  b_d     = sw;
                  state_d = S_F;
               end
            end
            S_F: begin
               if (ld) begin
                  fxn_d   = sw[FXN_W-1:0];
                  state_d = S_ISSUE;
                  valid_d = 1'b1;
               end
            end
            default: begin
               // S_ISSUE: ld is ignored; operands stay put until the transfer.
               if (op_ready) begin
                  state_d = S_A;
                  valid_d = 1'b0;
                  count_d = count_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         fxn_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fxn_q   <= fxn_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign fxn_out   = fxn_q;
   assign op_valid  = valid_q;
   assign state_out = state_q;
   assign op_count  = count_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed testbench for alu_operand_sequencer. Inputs change just after a falling edge and
// outputs are checked just after a falling edge.
module tb_alu_operand_sequencer;

   logic       clk;
   logic       reset;
   logic [5:0] sw;
   logic       load;
   logic       clear;
   logic       op_ready;
   logic [5:0] a_out;
   logic [5:0] b_out;
   logic [2:0] fxn_out;
   logic       op_valid;
   logic [1:0] state_out;
   logic [7:0] op_count;

   int vectors;
   int miscompares;

   alu_operand_sequencer #(
      .WIDTH (6),
      .FXN_W (3),
      .CNT_W (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw),
      .load      (load),
      .clear     (clear),
      .op_ready  (op_ready),
      .a_out     (a_out),
      .b_out     (b_out),
      .fxn_out   (fxn_out),
      .op_valid  (op_valid),
      .state_out (state_out),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One load cycle followed by an idle cycle, so a level-sensitive build also sees an edge.
   task automatic pulse_ld(input logic [5:0] v);
      sw   = v;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Full operation with op_ready already high: transfer happens on the edge after S_ISSUE.
   task automatic do_op(input logic [5:0] a, input logic [5:0] b, input logic [5:0] f);
      pulse_ld(a);
      idle();
      pulse_ld(b);
      idle();
      pulse_ld(f);
      idle();
   endtask

   task automatic test_reset_values();
      vectors++;
      if ({state_out, a_out, b_out, fxn_out, op_valid, op_count} !== 26'd0) begin
         miscompares++;
         $display("FAIL reset_values: got st=%0d a=%0d b=%0d f=%0d v=%0b cnt=%0d, need all 0",
                  state_out, a_out, b_out, fxn_out, op_valid, op_count);
      end
   endtask

   task automatic test_single_op();
      op_ready = 1'b1;
      pulse_ld(6'd13);
      vectors++;
      if (state_out !== 2'd1 || a_out !== 6'd13) begin
         miscompares++;
         $display("FAIL single_a: got st=%0d a=%0d, need st=1 a=13", state_out, a_out);
      end
      idle();
      pulse_ld(6'd50);
      vectors++;
      if (state_out !== 2'd2 || b_out !== 6'd50) begin
         miscompares++;
         $display("FAIL single_b: got st=%0d b=%0d, need st=2 b=50", state_out, b_out);
      end
      idle();
      pulse_ld(6'd5);
      vectors++;
      if (state_out !== 2'd3 || op_valid !== 1'b1 || fxn_out !== 3'd5 || op_count !== 8'd0) begin
         miscompares++;
         $display("FAIL single_issue: got st=%0d v=%0b f=%0d cnt=%0d, need st=3 v=1 f=5 cnt=0",
                  state_out, op_valid, fxn_out, op_count);
      end
      idle();
      vectors++;
      if (state_out !== 2'd0 || op_valid !== 1'b0 || op_count !== 8'd1 ||
          a_out !== 6'd13 || b_out !== 6'd50 || fxn_out !== 3'd5) begin
         miscompares++;
         $display("FAIL single_xfer: got st=%0d v=%0b cnt=%0d a=%0d b=%0d f=%0d, need 0 0 1 13 50 5",
                  state_out, op_valid, op_count, a_out, b_out, fxn_out);
      end
      op_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      pulse_ld(6'd9);
      vectors++;
      if (state_out !== 2'd1 || a_out !== 6'd9) begin
         miscompares++;
         $display("FAIL mid_reset_setup: got st=%0d a=%0d, need st=1 a=9", state_out, a_out);
      end
      #2 reset = 1'b1;
      #1;
      // Still before the next rising edge: only the asynchronous path can clear these.
      vectors++;
      if ({state_out, a_out, b_out, fxn_out, op_valid, op_count} !== 26'd0) begin
         miscompares++;
         $display("FAIL async_reset: got st=%0d a=%0d b=%0d f=%0d v=%0b cnt=%0d, need all 0",
                  state_out, a_out, b_out, fxn_out, op_valid, op_count);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      op_ready = 1'b0;
      pulse_ld(6'd33);
      idle();
      pulse_ld(6'd7);
      idle();
      pulse_ld(6'd62);  // upper bits dropped: fxn = 6
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            sw   = 6'd1;
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
         vectors++;
         if (state_out !== 2'd3 || op_valid !== 1'b1 || a_out !== 6'd33 || b_out !== 6'd7 ||
             fxn_out !== 3'd6 || op_count !== 8'd1) begin
            miscompares++;
            $display("FAIL hold_%0d: got st=%0d v=%0b a=%0d b=%0d f=%0d cnt=%0d, need 3 1 33 7 6 1",
                     i, state_out, op_valid, a_out, b_out, fxn_out, op_count);
         end
      end
      load = 1'b0;
      op_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (state_out !== 2'd0 || op_valid !== 1'b0 || op_count !== 8'd2) begin
         miscompares++;
         $display("FAIL hold_xfer: got st=%0d v=%0b cnt=%0d, need st=0 v=0 cnt=2",
                  state_out, op_valid, op_count);
      end
      // op_ready with nothing offered must not count.
      @(negedge clk);
      vectors++;
      if (state_out !== 2'd0 || op_count !== 8'd2) begin
         miscompares++;
         $display("FAIL ready_idle: got st=%0d cnt=%0d, need st=0 cnt=2", state_out, op_count);
      end
      op_ready = 1'b0;
   endtask

   task automatic test_clear_beats_xfer();
      pulse_ld(6'd21);
      idle();
      pulse_ld(6'd42);
      idle();
      pulse_ld(6'd3);
      vectors++;
      if (op_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_setup: got v=%0b, need 1", op_valid);
      end
      clear    = 1'b1;
      op_ready = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
      op_ready = 1'b0;
      vectors++;
      if (state_out !== 2'd0 || op_valid !== 1'b0 || a_out !== 6'd0 || b_out !== 6'd0 ||
          fxn_out !== 3'd0 || op_count !== 8'd2) begin
         miscompares++;
         $display("FAIL clear: got st=%0d v=%0b a=%0d b=%0d f=%0d cnt=%0d, need 0 0 0 0 0 2",
                  state_out, op_valid, a_out, b_out, fxn_out, op_count);
      end
      // clear beats ld too.
      sw    = 6'd11;
      load  = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      clear = 1'b0;
      vectors++;
      if (state_out !== 2'd0 || a_out !== 6'd0) begin
         miscompares++;
         $display("FAIL clear_vs_ld: got st=%0d a=%0d, need st=0 a=0", state_out, a_out);
      end
   endtask

   task automatic test_count_wrap();
      do_reset();
      op_ready = 1'b1;
      for (int i = 0; i < 255; i++) do_op(6'd1, 6'd2, 6'd3);
      vectors++;
      if (op_count !== 8'd255) begin
         miscompares++;
         $display("FAIL count_255: got cnt=%0d, need 255", op_count);
      end
      do_op(6'd4, 6'd5, 6'd6);
      vectors++;
      if (op_count !== 8'd0 || state_out !== 2'd0) begin
         miscompares++;
         $display("FAIL count_wrap: got cnt=%0d st=%0d, need cnt=0 st=0", op_count, state_out);
      end
      op_ready = 1'b0;
   endtask

   task automatic test_held_load();
      op_ready = 1'b0;
      sw       = 6'd63;
      load     = 1'b1;
      for (int i = 0; i < 20; i++) @(negedge clk);
      load = 1'b0;
      @(negedge clk);
`ifdef ALU_SEQ_LOAD_EDGE_EN
      vectors++;
      if (state_out !== 2'd1 || a_out !== 6'd63 || b_out !== 6'd0) begin
         miscompares++;
         $display("FAIL held_edge: got st=%0d a=%0d b=%0d, need st=1 a=63 b=0",
                  state_out, a_out, b_out);
      end
      pulse_ld(6'd21);
      vectors++;
      if (state_out !== 2'd2 || b_out !== 6'd21) begin
         miscompares++;
         $display("FAIL repress: got st=%0d b=%0d, need st=2 b=21", state_out, b_out);
      end
`else
      vectors++;
      if (state_out !== 2'd3 || op_valid !== 1'b1 || a_out !== 6'd63 || b_out !== 6'd63 ||
          fxn_out !== 3'd7) begin
         miscompares++;
         $display("FAIL held_level: got st=%0d v=%0b a=%0d b=%0d f=%0d, need 3 1 63 63 7",
                  state_out, op_valid, a_out, b_out, fxn_out);
      end
`endif
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_random_ops();
      logic [5:0] ra, rb, rf;
      logic [7:0] exp_cnt;
      exp_cnt = op_count;
      for (int i = 0; i < 24; i++) begin
         ra = 6'($urandom % 64);
         rb = 6'($urandom % 64);
         rf = 6'($urandom % 64);
         op_ready = 1'b0;
         pulse_ld(ra);
         idle();
         pulse_ld(rb);
         idle();
         pulse_ld(rf);
         vectors++;
         if (op_valid !== 1'b1 || a_out !== ra || b_out !== rb || fxn_out !== rf[2:0]) begin
            miscompares++;
            $display("FAIL rand_%0d: got v=%0b a=%0d b=%0d f=%0d, need v=1 a=%0d b=%0d f=%0d",
                     i, op_valid, a_out, b_out, fxn_out, ra, rb, rf[2:0]);
         end
         op_ready = 1'b1;
         @(negedge clk);
         exp_cnt = exp_cnt + 8'd1;
         vectors++;
         if (op_count !== exp_cnt || op_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_cnt_%0d: got cnt=%0d v=%0b, need cnt=%0d v=0",
                     i, op_count, op_valid, exp_cnt);
         end
      end
      op_ready = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      sw          = 6'd0;
      load        = 1'b0;
      clear       = 1'b0;
      op_ready    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      test_reset_values();
      reset = 1'b0;
      @(negedge clk);
      test_reset_values();
      test_single_op();
      test_backpressure();
      test_clear_beats_xfer();
      test_reset_mid_op();
      test_held_load();
      test_count_wrap();
      test_random_ops();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
